// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch front end with BOOT/RUN/HALT sequencing.
// It drives the PC to a combinational instruction memory. It squashes
// wrong-path words when a redirect arrives, and it holds for
// hazard-detector stalls.
// Optional feature macro: FETCH_PERF_CNT_EN builds the saturating
// stall/redirect performance counters. Without it, both counters read zero.
// Handshake note: there is no valid/ready pair here. pcNop is a level
// "hold" request that is sampled every RUN cycle. brTaken is a one-cycle
// redirect that acts on the edge ending the cycle in which it is high.
module fetch_ctrl #(
    parameter logic [15:0] NOP = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcNop,
    input  logic        brTaken,
    input  logic [15:0] brTarget,
    input  logic [15:0] instMem,
    output logic [15:0] pc,
    output logic [15:0] pcPlus2,
    output logic [15:0] fetch_inst,
    output logic        halted,
    output logic [15:0] stallCnt,
    output logic [15:0] redirCnt,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    // Only the upper 15 bits are stored, so pc[0] is structurally zero.
    logic [14:0] pc_hi;
    logic [15:0] pc_next;

    assign pc        = {pc_hi, 1'b0};
    assign pcPlus2   = pc + 16'd2;
    assign halted    = (state == HALT);
    assign state_dbg = state;

    // State and PC register; reset forces BOOT at address zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pc_hi <= 15'd0;
        end else begin
            state <= state_next;
            pc_hi <= pc_next[15:1];
        end
    end

    // Next-state, next-PC and fetched-word selection. A redirect outranks
    // a stall, and a stall outranks halt detection. A halt word seen while
    // stalled is therefore re-examined once the stall drops.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        fetch_inst = NOP;
        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                fetch_inst = brTaken ? NOP : instMem;
                if (brTaken) begin
                    pc_next = {brTarget[15:1], 1'b0};
                end else if (pcNop) begin
                    pc_next = pc;
                end else if (instMem[15:11] == 5'b00000) begin
                    state_next = HALT;
                end else begin
                    pc_next = pcPlus2;
                end
            end
            HALT: begin
                fetch_inst = brTaken ? NOP : instMem;
                if (brTaken) begin
                    pc_next    = {brTarget[15:1], 1'b0};
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    logic        stall_evt;
    logic        redir_evt;
    logic [15:0] stall_q;
    logic [15:0] redir_q;

    // A stall is counted only when it actually holds the PC in RUN.
    // A redirect is counted whenever it is acted upon.
    assign stall_evt = (state == RUN) && pcNop && !brTaken;
    assign redir_evt = (state != BOOT) && brTaken;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 16'd0;
            redir_q <= 16'd0;
        end else begin
            if (stall_evt && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
            if (redir_evt && (redir_q != 16'hFFFF)) redir_q <= redir_q + 16'd1;
        end
    end

    assign stallCnt = stall_q;
    assign redirCnt = redir_q;
`else
    assign stallCnt = 16'h0000;
    assign redirCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of fetch_ctrl sequencing, stall, redirect,
// halt, PC wrap and asynchronous reset. Build FETCH_PERF_CNT_EN to match
// the DUT build.
module tb_fetch_ctrl;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic        clk;
    logic        rst;
    logic        pcNop;
    logic        brTaken;
    logic [15:0] brTarget;
    logic [15:0] instMem;
    logic [15:0] pc;
    logic [15:0] pcPlus2;
    logic [15:0] fetch_inst;
    logic        halted;
    logic [15:0] stallCnt;
    logic [15:0] redirCnt;
    logic [1:0]  state_dbg;

    int total;
    int bad;

    fetch_ctrl #(.NOP(16'h0800)) dut (
        .clk        (clk),
        .rst        (rst),
        .pcNop      (pcNop),
        .brTaken    (brTaken),
        .brTarget   (brTarget),
        .instMem    (instMem),
        .pc         (pc),
        .pcPlus2    (pcPlus2),
        .fetch_inst (fetch_inst),
        .halted     (halted),
        .stallCnt   (stallCnt),
        .redirCnt   (redirCnt),
        .state_dbg  (state_dbg)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle clear of it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [15:0] cnt(input int n);
        return PERF ? 16'(n) : 16'd0;
    endfunction

    // One-cycle redirect to a target address.
    task automatic redirect(input logic [15:0] tgt);
        brTaken  = 1'b1;
        brTarget = tgt;
        #1;
        check("redir_squash", fetch_inst, 16'h0800);
        tick();
        brTaken = 1'b0;
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        pcNop    = 1'b0;
        brTaken  = 1'b0;
        brTarget = 16'h0000;
        instMem  = 16'h4000;

        // Reset and release: one BOOT cycle, then sequential fetch.
        #2 rst = 1'b1;
        #1;
        check("rst_pc", pc, 16'h0000);
        check("rst_inst", fetch_inst, 16'h0800);
        check("rst_halted", halted, 1'b0);
        check("rst_stallcnt", stallCnt, 16'h0000);
        check("rst_redircnt", redirCnt, 16'h0000);
        check("rst_state", state_dbg, S_BOOT);
        #19 rst = 1'b0;  // t=22, between edges
        #1;
        check("boot_pc", pc, 16'h0000);
        check("boot_inst", fetch_inst, 16'h0800);
        check("boot_pcplus2", pcPlus2, 16'h0002);
        tick();
        check("run0_state", state_dbg, S_RUN);
        check("run0_pc", pc, 16'h0000);
        check("run0_inst", fetch_inst, 16'h4000);
        tick();
        check("run1_pc", pc, 16'h0002);
        tick();
        check("run2_pc", pc, 16'h0004);
        tick();
        check("run3_pc", pc, 16'h0006);
        check("run3_pcplus2", pcPlus2, 16'h0008);

        // Stall for three cycles at 0x0010.
        redirect(16'h0010);
        check("stall_start_pc", pc, 16'h0010);
        check("redircnt_1", redirCnt, cnt(1));
        pcNop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_hold_pc", pc, 16'h0010);
            check("stall_inst", fetch_inst, 16'h4000);
            tick();
        end
        pcNop = 1'b0;
        #1;
        check("stall_end_pc", pc, 16'h0010);
        check("stallcnt_3", stallCnt, cnt(3));
        tick();
        check("stall_adv_pc", pc, 16'h0012);

        // Redirect and stall together: the redirect wins, and bit 0 is dropped.
        redirect(16'h0020);
        check("pc_0020", pc, 16'h0020);
        pcNop    = 1'b1;
        brTaken  = 1'b1;
        brTarget = 16'h0101;
        #1;
        check("both_squash", fetch_inst, 16'h0800);
        tick();
        pcNop   = 1'b0;
        brTaken = 1'b0;
        #1;
        check("both_pc", pc, 16'h0100);
        check("both_redircnt", redirCnt, cnt(3));
        check("both_stallcnt", stallCnt, cnt(3));

        // Halt at 0x0030, first seen while stalled.
        redirect(16'h0030);
        instMem = 16'h0000;
        pcNop   = 1'b1;
        tick();
        check("halt_stalled_h", halted, 1'b0);
        check("halt_stalled_pc", pc, 16'h0030);
        pcNop = 1'b0;
        tick();
        check("halt_entered", halted, 1'b1);
        check("halt_state", state_dbg, S_HALT);
        check("halt_stallcnt", stallCnt, cnt(4));
        for (int i = 0; i < 10; i++) begin
            pcNop = i[0];
            tick();
            check("halt_pc_frozen", pc, 16'h0030);
            check("halt_inst", fetch_inst, 16'h0000);
            check("halt_still", halted, 1'b1);
        end
        pcNop = 1'b0;
        check("halt_stallcnt_same", stallCnt, cnt(4));
        redirect(16'h0040);
        check("unhalt_h", halted, 1'b0);
        check("unhalt_pc", pc, 16'h0040);
        check("unhalt_redircnt", redirCnt, cnt(5));
        instMem = 16'h4000;
        #1;
        check("unhalt_inst", fetch_inst, 16'h4000);

        // PC wrap from 0xFFFE to 0x0000.
        redirect(16'hFFFE);
        check("wrap_pc", pc, 16'hFFFE);
        check("wrap_pcplus2", pcPlus2, 16'h0000);
        tick();
        check("wrap_next_pc", pc, 16'h0000);

        // Reset pulsed mid-HALT takes effect asynchronously.
        instMem = 16'h0000;
        tick();
        check("halt2_h", halted, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("async_pc", pc, 16'h0000);
        check("async_halted", halted, 1'b0);
        check("async_state", state_dbg, S_BOOT);
        check("async_inst", fetch_inst, 16'h0800);
        check("async_redircnt", redirCnt, 16'h0000);
        check("async_stallcnt", stallCnt, 16'h0000);
        #1 rst = 1'b0;
        instMem = 16'h4000;
        tick();
        check("reboot_state", state_dbg, S_RUN);
        check("reboot_pc", pc, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port pcNop  input  1  stall request from hazard detector; hold PC and fetch slot.
REQ-004 SHALL have port brTaken  input  1  control-flow redirect resolved downstream this cycle.
REQ-005 SHALL have port brTarget  input  16  redirect PC; bit 0 ignored.
REQ-006 SHALL have port instMem  input  16  combinational instruction-memory read data at address pc.
REQ-007 SHALL have port pc  output  16  current fetch address to instruction memory.
REQ-008 SHALL have port pcPlus2  output  16  pc+2, mod 2^16, forwarded for link/branch math.
REQ-009 SHALL have port fetch_inst  output  16  instruction presented to hazard detector.
REQ-010 SHALL have port halted  output  1  high while FSM in HALT.
REQ-011 SHALL have ports stallCnt, redirCnt  output  16 each  performance counters (see Configuration).
REQ-012 SHALL have parameter NOP, default 16'h0800, meaning the no-op encoding injected on squash/reset.

Function
REQ-013 SHALL implement FSM states BOOT, RUN, HALT; state held in a register.
REQ-014 BOOT->RUN unconditionally on the first clock edge after rst deasserts.
REQ-015 In BOOT: pc=0, fetch_inst=NOP, PC not advanced.
REQ-016 In RUN, next-PC priority: brTaken -> {brTarget[15:1],0}; else pcNop -> hold; else instMem[15:11]==5'b00000 (halt) -> hold and enter HALT; else pc+2.
REQ-017 PC increment SHALL wrap 16'hFFFE -> 16'h0000 with no flag.
REQ-018 pc[0] SHALL always be 0.
REQ-019 fetch_inst SHALL equal instMem in RUN/HALT, except NOP in any cycle where brTaken=1 (wrong-path squash, same cycle, combinational).
REQ-020 RUN->HALT requires brTaken=0 and pcNop=0 in that cycle; a halt seen while stalled SHALL be re-evaluated when stall clears.
REQ-021 In HALT: pc frozen; fetch_inst=instMem (the halt word); pcNop ignored.
REQ-022 HALT->RUN only on brTaken=1 (halt was wrong-path); pc loads brTarget on that edge.
REQ-023 brTaken and pcNop simultaneously: redirect wins; stall ignored that cycle.
REQ-024 pcPlus2 SHALL be combinational from pc, zero latency.
REQ-025 Instruction latency pc->fetch_inst SHALL be zero cycles (combinational memory path).

Reset
REQ-026 rst=1 SHALL, asynchronously: state=BOOT, pc=0, counters=0, halted=0, fetch_inst=NOP.
REQ-027 rst asserted mid-HALT or mid-stall SHALL abort immediately; no pending redirect retained.
REQ-028 No output SHALL be X after rst asserts.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN: when defined, stallCnt increments each RUN cycle with pcNop=1 and brTaken=0, redirCnt increments each cycle with brTaken=1; both saturate at 16'hFFFF.
REQ-030 Without FETCH_PERF_CNT_EN: counter registers not built; stallCnt and redirCnt tied to 16'h0000; all other behaviour identical.

Verification
REQ-031 Reset then release, instMem=16'h4000 always -> cycle 1 fetch_inst=16'h0800 pc=0; cycle 2 pc=0, fetch_inst=16'h4000; then pc 2,4,6.
REQ-032 RUN at pc=16'h0010, pcNop=1 for 3 cycles -> pc stays 16'h0010 3 cycles, then 16'h0012; stallCnt=3 with macro, 0 without.
REQ-033 pc=16'h0020, brTaken=1, pcNop=1, brTarget=16'h0101 -> fetch_inst=16'h0800 that cycle, next pc=16'h0100, redirCnt+1.
REQ-034 instMem=16'h0000 at pc=16'h0030 -> halted=1 next cycle, pc frozen 16'h0030 for 10 cycles; then brTaken=1, brTarget=16'h0040 -> halted=0, pc=16'h0040.
REQ-035 pc=16'hFFFE, no stall -> next pc=16'h0000, pcPlus2 at 16'hFFFE reads 16'h0000; rst pulsed mid-HALT -> pc=0, state BOOT asynchronously.
